// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants and types for the data RAM arbiter: memory geometry,
// the starvation bound and the port-select encoding used for response steering.
package data_ram_arbiter_pkg;

   localparam int DATA_RAM_SIZE             = 32768;
   localparam int AXI_DATA_WIDTH            = 32;
   localparam int DATA_RAM_ARB_STARVE_LIMIT = 4;
   localparam int STARVE_CNT_W              = 4;

   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_AXI  = 1'b1
   } port_sel_e;

   // Saturating starvation-count step; a grant to port 1 always wins over an increment.
   function automatic logic [STARVE_CNT_W-1:0] starve_next(
      input logic [STARVE_CNT_W-1:0] cnt,
      input logic                    p1_req,
      input logic                    p1_gnt,
      input logic [STARVE_CNT_W-1:0] limit
   );
      logic [STARVE_CNT_W-1:0] nxt;
      nxt = cnt;
      if (p1_gnt) begin
         nxt = '0;
      end else if (p1_req && (cnt < limit)) begin
         nxt = cnt + 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bundle of both requester ports plus the RAM macro side of the data RAM arbiter.
// The arbiter uses the slave modport; requesters and the RAM model use master.
interface data_ram_arbiter_if
   import data_ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = $clog2(DATA_RAM_SIZE),
   parameter int DATA_WIDTH = AXI_DATA_WIDTH
);

   localparam int BE_W = DATA_WIDTH / 8;

   logic                  p0_req;
   logic [ADDR_WIDTH-1:0] p0_addr;
   logic                  p0_we;
   logic [BE_W-1:0]       p0_be;
   logic [DATA_WIDTH-1:0] p0_wdata;
   logic                  p0_gnt;
   logic                  p0_rvalid;
   logic [DATA_WIDTH-1:0] p0_rdata;

   logic                  p1_req;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic                  p1_we;
   logic [BE_W-1:0]       p1_be;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic                  p1_gnt;
   logic                  p1_rvalid;
   logic [DATA_WIDTH-1:0] p1_rdata;

   logic                  ram_en;
   logic [ADDR_WIDTH-3:0] ram_addr;
   logic                  ram_we;
   logic [BE_W-1:0]       ram_be;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  p0_req, p0_addr, p0_we, p0_be, p0_wdata,
      output p0_gnt, p0_rvalid, p0_rdata,
      input  p1_req, p1_addr, p1_we, p1_be, p1_wdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output ram_en, ram_addr, ram_we, ram_be, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output p0_req, p0_addr, p0_we, p0_be, p0_wdata,
      input  p0_gnt, p0_rvalid, p0_rdata,
      output p1_req, p1_addr, p1_we, p1_be, p1_wdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  ram_en, ram_addr, ram_we, ram_be, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/data_ram_arbiter.sv
// Fixed-priority arbiter for the single-port data RAM: core (port 0) wins
// conflicts until the AXI bridge (port 1) has lost STARVE_LIMIT in a row.
module data_ram_arbiter
   import data_ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = $clog2(DATA_RAM_SIZE),
   parameter int DATA_WIDTH   = AXI_DATA_WIDTH,
   parameter int STARVE_LIMIT = DATA_RAM_ARB_STARVE_LIMIT
) (
   input  logic                     clk,
   input  logic                     rst,
   data_ram_arbiter_if.slave        bus
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] r_starve_cnt;
   port_sel_e               r_resp_sel;
   logic                    r_resp_pend;

   port_sel_e               w_win;
   logic                    w_p0_gnt;
   logic                    w_p1_gnt;
   logic                    w_any_gnt;
   logic [STARVE_CNT_W-1:0] w_starve_nxt;

   always_comb begin
      w_win = PORT_CORE;
      if (bus.p1_req && (!bus.p0_req || (r_starve_cnt == LIMIT))) begin
         w_win = PORT_AXI;
      end
   end

   // Grants are suppressed during reset so nothing reaches the RAM.
   assign w_p0_gnt  = !rst && bus.p0_req && (w_win == PORT_CORE);
   assign w_p1_gnt  = !rst && bus.p1_req && (w_win == PORT_AXI);
   assign w_any_gnt = w_p0_gnt || w_p1_gnt;

   assign bus.p0_gnt = w_p0_gnt;
   assign bus.p1_gnt = w_p1_gnt;

   always_comb begin
      bus.ram_en    = w_any_gnt;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = bus.p0_addr[ADDR_WIDTH-1:2];
      bus.ram_be    = bus.p0_be;
      bus.ram_wdata = bus.p0_wdata;
      if (w_win == PORT_AXI) begin
         bus.ram_addr  = bus.p1_addr[ADDR_WIDTH-1:2];
         bus.ram_be    = bus.p1_be;
         bus.ram_wdata = bus.p1_wdata;
         bus.ram_we    = w_any_gnt && bus.p1_we;
      end else begin
         bus.ram_we    = w_any_gnt && bus.p0_we;
      end
   end

   assign w_starve_nxt = starve_next(r_starve_cnt, bus.p1_req, w_p1_gnt, LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else begin
         r_starve_cnt <= w_starve_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_pend <= 1'b0;
         r_resp_sel  <= PORT_CORE;
      end else begin
         r_resp_pend <= w_any_gnt;
         if (w_any_gnt) begin
            r_resp_sel <= w_win;
         end
      end
   end

   // Response steering: the port that did not issue the access sees zero data.
   always_comb begin
      bus.p0_rvalid = r_resp_pend && (r_resp_sel == PORT_CORE);
      bus.p1_rvalid = r_resp_pend && (r_resp_sel == PORT_AXI);
      bus.p0_rdata  = '0;
      bus.p1_rdata  = '0;
      if (r_resp_sel == PORT_CORE) begin
         bus.p0_rdata = bus.ram_rdata;
      end else begin
         bus.p1_rdata = bus.ram_rdata;
      end
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of arbitration and memory contents.
module tb_data_ram_arbiter;
   import data_ram_arbiter_pkg::*;

   localparam int LIMIT = 4;
   localparam int NW    = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_ram_arbiter_if bus ();

   data_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM macro model: 1-cycle read latency, byte-enable writes, plus a preload port.
   logic [31:0] ram_mem [0:NW-1];
   logic        poke_en = 1'b0;
   logic [5:0]  poke_addr = '0;
   logic [31:0] poke_data = '0;

   always @(posedge clk) begin
      if (poke_en) begin
         ram_mem[poke_addr] <= poke_data;
      end else if (bus.ram_en) begin
         if (bus.ram_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_be[b]) ram_mem[bus.ram_addr[5:0]][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
         end else begin
            bus.ram_rdata <= ram_mem[bus.ram_addr[5:0]];
         end
      end
   end

   logic [31:0] ref_mem [0:NW-1];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic idle_inputs();
      bus.p0_req = 1'b0; bus.p0_addr = '0; bus.p0_we = 1'b0; bus.p0_be = 4'hF; bus.p0_wdata = '0;
      bus.p1_req = 1'b0; bus.p1_addr = '0; bus.p1_we = 1'b0; bus.p1_be = 4'hF; bus.p1_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; idle_inputs();
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic poke(input int w, input logic [31:0] d);
      @(negedge clk); poke_en = 1'b1; poke_addr = 6'(w); poke_data = d; ref_mem[w] = d;
      @(negedge clk); poke_en = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1'b1;
      bus.p0_req = 1'b1; bus.p0_addr = 15'h0010; bus.p1_req = 1'b1; bus.p1_addr = 15'h0020;
      #1;
      n_chk++; if (bus.p0_gnt !== 1'b0) $display("FAIL rst_p0_gnt got=%b exp=0", bus.p0_gnt); else n_pass++;
      n_chk++; if (bus.p1_gnt !== 1'b0) $display("FAIL rst_p1_gnt got=%b exp=0", bus.p1_gnt); else n_pass++;
      n_chk++; if (bus.ram_en !== 1'b0) $display("FAIL rst_ram_en got=%b exp=0", bus.ram_en); else n_pass++;
      n_chk++; if (bus.ram_we !== 1'b0) $display("FAIL rst_ram_we got=%b exp=0", bus.ram_we); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.p0_rvalid !== 1'b0) $display("FAIL rst_p0_rvalid got=%b exp=0", bus.p0_rvalid); else n_pass++;
      n_chk++; if (bus.p1_rvalid !== 1'b0) $display("FAIL rst_p1_rvalid got=%b exp=0", bus.p1_rvalid); else n_pass++;
      n_chk++; if (dut.r_starve_cnt !== 4'd0) $display("FAIL rst_starve got=%0d exp=0", dut.r_starve_cnt); else n_pass++;
      @(negedge clk); rst = 1'b0; idle_inputs();
   endtask

   task automatic test_p0_read();
      poke(4, 32'hDEADBEEF);
      @(negedge clk); bus.p0_req = 1'b1; bus.p0_addr = 15'h0010; bus.p0_we = 1'b0;
      #1;
      n_chk++; if (bus.p0_gnt !== 1'b1) $display("FAIL p0rd_gnt got=%b exp=1", bus.p0_gnt); else n_pass++;
      n_chk++; if (bus.p1_gnt !== 1'b0) $display("FAIL p0rd_p1_gnt got=%b exp=0", bus.p1_gnt); else n_pass++;
      n_chk++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) $display("FAIL p0rd_en_we got=%b%b exp=10", bus.ram_en, bus.ram_we); else n_pass++;
      n_chk++; if (bus.ram_addr !== 13'd4) $display("FAIL p0rd_addr got=%0d exp=4", bus.ram_addr); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.p0_rvalid !== 1'b1) $display("FAIL p0rd_rvalid got=%b exp=1", bus.p0_rvalid); else n_pass++;
      n_chk++; if (bus.p0_rdata !== 32'hDEADBEEF) $display("FAIL p0rd_rdata got=%h exp=deadbeef", bus.p0_rdata); else n_pass++;
      n_chk++; if (bus.p1_rvalid !== 1'b0) $display("FAIL p0rd_p1_rvalid got=%b exp=0", bus.p1_rvalid); else n_pass++;
      n_chk++; if (bus.p1_rdata !== 32'h0) $display("FAIL p0rd_p1_rdata got=%h exp=0", bus.p1_rdata); else n_pass++;
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      n_chk++; if (bus.p0_rvalid !== 1'b0) $display("FAIL p0rd_rvalid_drop got=%b exp=0", bus.p0_rvalid); else n_pass++;
   endtask

   task automatic test_starvation();
      do_reset();
      @(negedge clk);
      bus.p0_req = 1'b1; bus.p0_addr = 15'h0000; bus.p1_req = 1'b1; bus.p1_addr = 15'h0004;
      for (int c = 0; c < 10; c++) begin
         #1;
         n_chk++; if (bus.p1_gnt !== ((c % 5) == 4)) $display("FAIL starve_p1_gnt cyc=%0d got=%b exp=%b", c, bus.p1_gnt, (c % 5) == 4); else n_pass++;
         n_chk++; if (bus.p0_gnt !== ((c % 5) != 4)) $display("FAIL starve_p0_gnt cyc=%0d got=%b exp=%b", c, bus.p0_gnt, (c % 5) != 4); else n_pass++;
         n_chk++; if (dut.r_starve_cnt !== 4'(c % 5)) $display("FAIL starve_cnt cyc=%0d got=%0d exp=%0d", c, dut.r_starve_cnt, c % 5); else n_pass++;
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_p1_write();
      poke(8, 32'hAABBCCDD);
      @(negedge clk);
      bus.p1_req = 1'b1; bus.p1_addr = 15'h0020; bus.p1_we = 1'b1; bus.p1_be = 4'b0011; bus.p1_wdata = 32'h12345678;
      #1;
      n_chk++; if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0) $display("FAIL p1wr_gnt got=%b%b exp=10", bus.p1_gnt, bus.p0_gnt); else n_pass++;
      n_chk++; if (bus.ram_we !== 1'b1 || bus.ram_en !== 1'b1) $display("FAIL p1wr_we got=%b exp=1", bus.ram_we); else n_pass++;
      n_chk++; if (bus.ram_be !== 4'b0011) $display("FAIL p1wr_be got=%b exp=0011", bus.ram_be); else n_pass++;
      n_chk++; if (bus.ram_addr !== 13'd8) $display("FAIL p1wr_addr got=%0d exp=8", bus.ram_addr); else n_pass++;
      n_chk++; if (bus.ram_wdata !== 32'h12345678) $display("FAIL p1wr_wdata got=%h exp=12345678", bus.ram_wdata); else n_pass++;
      ref_mem[8] = 32'hAABB5678;
      @(posedge clk); #1;
      n_chk++; if (bus.p1_rvalid !== 1'b1 || bus.p0_rvalid !== 1'b0) $display("FAIL p1wr_rvalid got=%b%b exp=10", bus.p1_rvalid, bus.p0_rvalid); else n_pass++;
      @(negedge clk); bus.p1_we = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (bus.p1_rvalid !== 1'b1) $display("FAIL p1rb_rvalid got=%b exp=1", bus.p1_rvalid); else n_pass++;
      n_chk++; if (bus.p1_rdata !== 32'hAABB5678) $display("FAIL p1rb_rdata got=%h exp=aabb5678", bus.p1_rdata); else n_pass++;
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_alternating();
      poke(16, 32'h11112222);
      poke(17, 32'h33334444);
      @(negedge clk); bus.p0_req = 1'b1; bus.p0_addr = 15'h0040;
      #1;
      n_chk++; if (bus.p0_gnt !== 1'b1) $display("FAIL alt_p0_gnt got=%b exp=1", bus.p0_gnt); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h11112222) $display("FAIL alt_p0_resp got=%b/%h exp=1/11112222", bus.p0_rvalid, bus.p0_rdata); else n_pass++;
      n_chk++; if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 32'h0) $display("FAIL alt_p1_quiet got=%b/%h exp=0/0", bus.p1_rvalid, bus.p1_rdata); else n_pass++;
      @(negedge clk); bus.p0_req = 1'b0; bus.p1_req = 1'b1; bus.p1_addr = 15'h0044; bus.p1_we = 1'b0;
      #1;
      n_chk++; if (bus.p1_gnt !== 1'b1) $display("FAIL alt_p1_gnt got=%b exp=1", bus.p1_gnt); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 32'h33334444) $display("FAIL alt_p1_resp got=%b/%h exp=1/33334444", bus.p1_rvalid, bus.p1_rdata); else n_pass++;
      n_chk++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'h0) $display("FAIL alt_p0_quiet got=%b/%h exp=0/0", bus.p0_rvalid, bus.p0_rdata); else n_pass++;
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk); bus.p0_req = 1'b1; bus.p0_addr = 15'h0040; bus.p1_req = 1'b1; bus.p1_addr = 15'h0044;
      @(negedge clk); #1;
      n_chk++; if (bus.p0_gnt !== 1'b1 || dut.r_starve_cnt !== 4'd1) $display("FAIL rmid_pre got=%b/%0d exp=1/1", bus.p0_gnt, dut.r_starve_cnt); else n_pass++;
      @(negedge clk); rst = 1'b1;
      #1;
      n_chk++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) $display("FAIL rmid_gnt got=%b%b exp=00", bus.p0_gnt, bus.p1_gnt); else n_pass++;
      n_chk++; if (bus.ram_en !== 1'b0) $display("FAIL rmid_ram_en got=%b exp=0", bus.ram_en); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) $display("FAIL rmid_rvalid got=%b%b exp=00", bus.p0_rvalid, bus.p1_rvalid); else n_pass++;
      n_chk++; if (dut.r_starve_cnt !== 4'd0) $display("FAIL rmid_starve got=%0d exp=0", dut.r_starve_cnt); else n_pass++;
      @(negedge clk); rst = 1'b0; idle_inputs();
   endtask

   task automatic test_p1_only();
      int w;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         w = $urandom_range(0, NW - 1);
         bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 15'(w * 4);
         #1;
         n_chk++; if (bus.p1_gnt !== 1'b1) $display("FAIL p1only_gnt i=%0d got=%b exp=1", i, bus.p1_gnt); else n_pass++;
         n_chk++; if (dut.r_starve_cnt !== 4'd0) $display("FAIL p1only_starve i=%0d got=%0d exp=0", i, dut.r_starve_cnt); else n_pass++;
         @(posedge clk); #1;
         n_chk++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== ref_mem[w]) $display("FAIL p1only_resp i=%0d got=%b/%h exp=1/%h", i, bus.p1_rvalid, bus.p1_rdata, ref_mem[w]); else n_pass++;
      end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_random();
      logic        pv_req [2];
      logic [14:0] pv_addr [2];
      logic        pv_we [2];
      logic [3:0]  pv_be [2];
      logic [31:0] pv_wd [2];
      int          m_starve;
      int          win;
      int          w;
      logic        p1_wanted;
      logic [31:0] exp_data;
      do_reset();
      m_starve = 0;
      for (int p = 0; p < 2; p++) pv_req[p] = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (!pv_req[p] && ($urandom_range(0, 99) < 65)) begin
               pv_req[p]  = 1'b1;
               pv_addr[p] = 15'($urandom_range(0, NW * 4 - 1));
               pv_we[p]   = ($urandom_range(0, 2) == 0);
               pv_be[p]   = 4'($urandom);
               pv_wd[p]   = $urandom;
            end
         end
         bus.p0_req = pv_req[0]; bus.p0_addr = pv_addr[0]; bus.p0_we = pv_we[0]; bus.p0_be = pv_be[0]; bus.p0_wdata = pv_wd[0];
         bus.p1_req = pv_req[1]; bus.p1_addr = pv_addr[1]; bus.p1_we = pv_we[1]; bus.p1_be = pv_be[1]; bus.p1_wdata = pv_wd[1];
         win = -1;
         if (pv_req[0] && pv_req[1]) win = (m_starve >= LIMIT) ? 1 : 0;
         else if (pv_req[0]) win = 0;
         else if (pv_req[1]) win = 1;
         #1;
         n_chk++; if (bus.p0_gnt !== (win == 0) || bus.p1_gnt !== (win == 1)) $display("FAIL rnd_gnt cyc=%0d got=%b%b exp_win=%0d", cyc, bus.p0_gnt, bus.p1_gnt, win); else n_pass++;
         n_chk++; if (dut.r_starve_cnt !== 4'(m_starve)) $display("FAIL rnd_starve cyc=%0d got=%0d exp=%0d", cyc, dut.r_starve_cnt, m_starve); else n_pass++;
         n_chk++; if (bus.ram_en !== (win >= 0)) $display("FAIL rnd_ram_en cyc=%0d got=%b exp=%b", cyc, bus.ram_en, win >= 0); else n_pass++;
         exp_data = '0;
         if (win >= 0) begin
            w = int'(pv_addr[win][7:2]);
            n_chk++; if (bus.ram_addr !== 13'(w) || bus.ram_we !== pv_we[win]) $display("FAIL rnd_ram_cmd cyc=%0d got=%0d/%b exp=%0d/%b", cyc, bus.ram_addr, bus.ram_we, w, pv_we[win]); else n_pass++;
            if (pv_we[win]) begin
               n_chk++; if (bus.ram_be !== pv_be[win] || bus.ram_wdata !== pv_wd[win]) $display("FAIL rnd_ram_wr cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.ram_be, bus.ram_wdata, pv_be[win], pv_wd[win]); else n_pass++;
               for (int b = 0; b < 4; b++)
                  if (pv_be[win][b]) ref_mem[w][b*8 +: 8] = pv_wd[win][b*8 +: 8];
            end else begin
               exp_data = ref_mem[w];
            end
         end
         p1_wanted = pv_req[1];
         if (win == 1) m_starve = 0;
         else if (p1_wanted && m_starve < LIMIT) m_starve++;
         @(posedge clk); #1;
         n_chk++; if (bus.p0_rvalid !== (win == 0) || bus.p1_rvalid !== (win == 1)) $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp_win=%0d", cyc, bus.p0_rvalid, bus.p1_rvalid, win); else n_pass++;
         if (win == 0) begin
            if (!pv_we[0]) begin
               n_chk++; if (bus.p0_rdata !== exp_data) $display("FAIL rnd_p0_rdata cyc=%0d got=%h exp=%h", cyc, bus.p0_rdata, exp_data); else n_pass++;
            end
            n_chk++; if (bus.p1_rdata !== 32'h0) $display("FAIL rnd_p1_zero cyc=%0d got=%h exp=0", cyc, bus.p1_rdata); else n_pass++;
            pv_req[0] = 1'b0;
         end else if (win == 1) begin
            if (!pv_we[1]) begin
               n_chk++; if (bus.p1_rdata !== exp_data) $display("FAIL rnd_p1_rdata cyc=%0d got=%h exp=%h", cyc, bus.p1_rdata, exp_data); else n_pass++;
            end
            n_chk++; if (bus.p0_rdata !== 32'h0) $display("FAIL rnd_p0_zero cyc=%0d got=%h exp=0", cyc, bus.p0_rdata); else n_pass++;
            pv_req[1] = 1'b0;
         end
      end
      @(negedge clk); idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < NW; i++) poke(i, $urandom);
      @(negedge clk); rst = 1'b0;
      test_reset();
      test_p0_read();
      test_starvation();
      test_p1_write();
      test_alternating();
      test_reset_mid();
      test_p1_only();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares the single-port data RAM (DATA_RAM_SIZE bytes, 32-bit words) between two requesters: the core data port (port 0) and the AXI-to-memory bridge (port 1). Port 0 has fixed priority, and a starvation counter bounds how long port 1 can wait. Read data returns with a 1-cycle latency and is steered to the port that issued the access. The block sits between the core/AXI bus interfaces and the data RAM macro inside the core region.

## Interface
- ADDR_WIDTH, default $clog2(DATA_RAM_SIZE) = 15: byte-address width presented by both ports.
- DATA_WIDTH, default AXI_DATA_WIDTH = 32: word width.
- STARVE_LIMIT, default 4: consecutive lost conflicts after which port 1 wins. Legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req / p1_req  in  1  access request.
- p0_addr / p1_addr  in  ADDR_WIDTH  byte address. Bits [1:0] are ignored.
- p0_we / p1_we  in  1  1 = write.
- p0_be / p1_be  in  DATA_WIDTH/8  byte enables.
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data.
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational).
- p0_rvalid / p1_rvalid  out  1  response valid, one cycle after gnt.
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data, meaningful when the port's rvalid is high.
- ram_en  out  1  RAM access strobe.
- ram_addr  out  ADDR_WIDTH-2  word address.
- ram_we  out  1  write enable.
- ram_be  out  DATA_WIDTH/8  byte enables.
- ram_wdata  out  DATA_WIDTH  write data.
- ram_rdata  in  DATA_WIDTH  RAM output, valid one cycle after a read.

## Operation
- At most one RAM access per cycle. A grant occurs whenever the winning port has req high, with no backpressure from the RAM.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting and starve_cnt < STARVE_LIMIT: port 0 wins.
  - Both requesting and starve_cnt == STARVE_LIMIT: port 1 wins.
- starve_cnt (4 bits) updates as follows:
  - Cleared on any p1_gnt.
  - Incremented when p1_req is high and p1 is not granted.
  - Held otherwise, including when p1_req drops without a grant.
  - Saturates at STARVE_LIMIT.
- The RAM outputs are driven from the winner's signals, with ram_addr = addr[ADDR_WIDTH-1:2]. When no port is granted, ram_en = 0 and ram_we = 0; the other RAM outputs are don't-care but are driven from port 0.
- resp_sel (1 bit) and resp_pend (1 bit) are registered on every grant.
- rvalid is asserted one cycle after gnt on the granted port, for both reads and writes.
  - p*_rdata = ram_rdata, routed combinationally by resp_sel.
  - On a write response, rdata is don't-care.
- The non-selected port's rdata is driven to 0.
- Requesters must hold their request signals stable until gnt. The arbiter does not check this.

## Timing
- Reset values: starve_cnt = 0, resp_pend = 0, resp_sel = 0. All rvalid outputs are 0 in the cycle after rst is sampled high.
- gnt and ram_* are combinational from the req inputs and starve_cnt, giving zero cycles from req to RAM.
- Read latency: gnt at cycle N gives rvalid and rdata at cycle N+1.
- Back-to-back grants are allowed every cycle, including alternating ports. A response in cycle N+1 and a new grant in cycle N+1 coexist.
- When rst is asserted mid-operation, any pending response is dropped (no rvalid) and starve_cnt is cleared. gnt is forced to 0 while rst is high.
- Simultaneous p1 grant and counter saturation is not a conflict: the clear takes precedence over the increment.

## Structure
- DATA_RAM_SIZE and AXI_DATA_WIDTH come from the shared RISCV_MCU_CONFIG package.
- Add the port-select enum (PORT_CORE = 1'b0, PORT_AXI = 1'b1) and the DATA_RAM_ARB_STARVE_LIMIT constant to that package.
- No sub-module is required. The starvation counter is the only candidate, as data_ram_arb_starve_cnt, but it stays inline.

## Test plan
- Port 0 reads address 0x0010 with RAM word 4 = 0xDEADBEEF: p0_gnt in the same cycle, ram_addr = 4, then p0_rvalid = 1 with p0_rdata = 0xDEADBEEF next cycle; p1_rvalid stays 0.
- Both ports request continuously, STARVE_LIMIT = 4: grants go p0, p0, p0, p0, p1, then p0 ×4, p1, repeating; starve_cnt reaches 4 before each p1 grant.
- Port 1 writes 0x12345678 with be = 4'b0011 to 0x0020: ram_we = 1, ram_be = 0011, ram_addr = 8; p1_rvalid = 1 next cycle; a following read of word 8 returns the written bytes.
- Alternating p0 read then p1 read in consecutive cycles: responses arrive on p0 then p1 in consecutive cycles, each with the correct ram_rdata and no crossover.
- Assert rst in the cycle after a p0 read grant: no p0_rvalid, starve_cnt = 0, and all gnt = 0 while rst is high.
- p1_req held with p0 idle: p1_gnt every cycle and starve_cnt stays 0.
